// File: rtl/tm1637_responder.sv
// TM1637 target model: decodes host START/STOP/bytes/commands, ACKs each byte, holds committed display state (optional key read: TM1637_KEYSCAN_EN).
// Latency: every bus edge acts SYNC_STAGES+1 clk cycles after it reaches the pins; seg_flat commits at STOP + that latency.
// Backpressure: none; the host paces the bus, and each CLK phase must last at least SYNC_STAGES+3 clk cycles.
module tm1637_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tm_clk,
    inout  wire         tm_dio,
    input  logic [7:0]  key_code,
    output logic [47:0] seg_flat,
    output logic        disp_on,
    output logic [2:0]  brightness,
    output logic        auto_inc,
    output logic        frame_done,
    output logic        proto_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ACK, S_DATA, S_EXTRA, S_IGNORE, S_READ, S_WAIT
    } state_t;

    state_t state, ack_next;
    logic [SYNC_STAGES-1:0] clk_sync, dio_sync;
    logic        clk_prev, dio_prev;
    logic        clk_s, dio_s;
    logic        clk_rise, clk_fall, start_det, stop_det, stop_mid;
    logic [6:0]  shift_r;
    logic [7:0]  byte_full;
    logic [2:0]  bit_cnt;
    logic [2:0]  addr;
    logic [47:0] shadow;
    logic        frame_err, addr_frame, ack_drv, dio_oe;

`ifdef TM1637_KEYSCAN_EN
    logic [7:0]  key_r;
    logic [2:0]  rd_cnt, rd_nxt;
    assign rd_nxt = rd_cnt + 3'd1;
`else
    logic unused_key;
    assign unused_key = ^key_code;
`endif

    // Open-drain: only ever pull low, the external pull-up provides the high level.
    assign tm_dio = dio_oe ? 1'b0 : 1'bz;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign dio_s     = dio_sync[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~clk_prev;
    assign clk_fall  = ~clk_s & clk_prev;
    assign start_det = dio_prev & ~dio_s & clk_s;
    assign stop_det  = ~dio_prev & dio_s & clk_s;
    assign byte_full = {dio_s, shift_r};
    // A normal STOP is preceded by one CLK rise with DIO low, so one captured bit is not a torn byte.
    assign stop_mid  = (state == S_ACK) || (state == S_READ) || (bit_cnt > 3'd1);

    // Synchronise the bus lines and keep the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dio_sync <= '1;
            clk_prev <= 1'b1;
            dio_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], tm_clk};
            dio_sync <= {dio_sync[SYNC_STAGES-2:0], tm_dio};
            clk_prev <= clk_s;
            dio_prev <= dio_s;
        end
    end

    // Frame FSM: bit capture, command decode, ACK/read drive, shadow writes and atomic commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ack_next   <= S_IDLE;
            shift_r    <= '0;
            bit_cnt    <= '0;
            addr       <= '0;
            shadow     <= '0;
            seg_flat   <= '0;
            disp_on    <= 1'b0;
            brightness <= '0;
            auto_inc   <= 1'b1;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
            frame_err  <= 1'b0;
            addr_frame <= 1'b0;
            ack_drv    <= 1'b0;
            dio_oe     <= 1'b0;
`ifdef TM1637_KEYSCAN_EN
            key_r      <= '0;
            rd_cnt     <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
            if (clk_rise) begin
                if (state inside {S_CMD, S_DATA, S_EXTRA, S_IGNORE}) begin
                    shift_r <= byte_full[7:1];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state    <= S_ACK;
                        ack_drv  <= 1'b0;
                        ack_next <= state;
                        case (state)
                            S_CMD: begin
                                if (byte_full[7:3] == 5'b01000 && byte_full[1:0] == 2'b00) begin
                                    auto_inc <= ~byte_full[2];
                                    ack_next <= S_EXTRA;
                                end
`ifdef TM1637_KEYSCAN_EN
                                else if (byte_full[7:3] == 5'b01000 && byte_full[1:0] == 2'b10) begin
                                    auto_inc <= ~byte_full[2];
                                    ack_next <= S_READ;
                                end
`endif
                                else if (byte_full[7:4] == 4'b1000) begin
                                    disp_on    <= byte_full[3];
                                    brightness <= byte_full[2:0];
                                    ack_next   <= S_EXTRA;
                                end else if (byte_full[7:3] == 5'b11000) begin
                                    addr       <= byte_full[2:0];
                                    addr_frame <= 1'b1;
                                    ack_next   <= S_DATA;
                                end else begin
                                    proto_err <= 1'b1;
                                    frame_err <= 1'b1;
                                    ack_next  <= S_IGNORE;
                                end
                            end
                            S_DATA: begin
                                // Addresses 6 and 7 do not exist: byte dropped, address parks there.
                                if (addr < 3'd6) begin
                                    shadow[{addr, 3'b000} +: 8] <= byte_full;
                                    if (auto_inc) addr <= addr + 3'd1;
                                end
                            end
                            S_EXTRA: begin
                                proto_err <= 1'b1;
                                frame_err <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (clk_fall) begin
                if (state == S_ACK) begin
                    if (!ack_drv) begin
                        ack_drv <= 1'b1;
                        dio_oe  <= 1'b1;
                    end else begin
                        ack_drv <= 1'b0;
                        dio_oe  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ack_next;
`ifdef TM1637_KEYSCAN_EN
                        if (ack_next == S_READ) begin
                            key_r  <= key_code;
                            rd_cnt <= '0;
                            dio_oe <= ~key_code[0];
                        end
`endif
                    end
                end
`ifdef TM1637_KEYSCAN_EN
                else if (state == S_READ) begin
                    if (rd_cnt != 3'd7) begin
                        rd_cnt <= rd_nxt;
                        dio_oe <= ~key_r[rd_nxt];
                    end else begin
                        dio_oe <= 1'b0;
                        state  <= S_WAIT;
                    end
                end
`endif
            end else if (start_det) begin
                // Any START restarts the frame; unfinished writes are thrown away.
                if (state != S_IDLE) proto_err <= 1'b1;
                state      <= S_CMD;
                bit_cnt    <= '0;
                frame_err  <= 1'b0;
                addr_frame <= 1'b0;
                ack_drv    <= 1'b0;
                dio_oe     <= 1'b0;
                shadow     <= seg_flat;
            end else if (stop_det) begin
                ack_drv <= 1'b0;
                dio_oe  <= 1'b0;
                if (state != S_IDLE) begin
                    state <= S_IDLE;
                    if (stop_mid) begin
                        proto_err <= 1'b1;
                    end else if (!frame_err && state != S_CMD) begin
                        frame_done <= 1'b1;
                        if (addr_frame) seg_flat <= shadow;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tm1637_responder.sv
module tb_tm1637_responder;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tm_clk = 1'b1;
    logic        dio_low = 1'b0;
    logic [7:0]  key_code = 8'hA5;
    wire         tm_dio;
    logic [47:0] seg_flat;
    logic        disp_on;
    logic [2:0]  brightness;
    logic        auto_inc;
    logic        frame_done;
    logic        proto_err;

    assign tm_dio = dio_low ? 1'b0 : 1'bz;
    pullup (tm_dio);

    always #10 clk = ~clk;

    tm1637_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .tm_clk(tm_clk), .tm_dio(tm_dio), .key_code(key_code),
        .seg_flat(seg_flat), .disp_on(disp_on), .brightness(brightness), .auto_inc(auto_inc),
        .frame_done(frame_done), .proto_err(proto_err)
    );

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int pe_cnt = 0;

    // Count output pulses so each sequence can compare deltas.
    always @(posedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (proto_err)  pe_cnt <= pe_cnt + 1;
    end

    typedef struct {
        int          nb;
        logic [47:0] bytes;
        logic [47:0] seg;
        logic        disp;
        logic [2:0]  bri;
        logic        ai;
        int          fd;
        int          pe;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cond();
        dio_low = 1'b0; wait_clk(H);
        tm_clk = 1'b1;  wait_clk(H);
        dio_low = 1'b1; wait_clk(H);
        tm_clk = 1'b0;  wait_clk(H);
    endtask

    task automatic stop_cond();
        wait_clk(2);
        dio_low = 1'b1; wait_clk(H);
        tm_clk = 1'b1;  wait_clk(H);
        dio_low = 1'b0; wait_clk(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            wait_clk(2);
            dio_low = ~b[i]; wait_clk(H);
            tm_clk = 1'b1;   wait_clk(H);
            tm_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [2:0] a;
        send_bits(b, 8);
        wait_clk(2); dio_low = 1'b0; wait_clk(2);
        a[2] = tm_dio;
        wait_clk(H - 4); tm_clk = 1'b1; wait_clk(H / 2);
        a[1] = tm_dio;
        wait_clk(H / 2); tm_clk = 1'b0; wait_clk(4);
        a[0] = tm_dio;
        wait_clk(H - 4);
        check($sformatf("ack_%02h", b), {61'd0, a}, 64'd1);
    endtask

    initial begin
        int fd0, pe0;
        logic [47:0] exp_seg;
        logic [7:0] rd, rd_exp;

        tbl[0]  = '{1, 48'h40,         48'h0,            1'b0, 3'd0, 1'b1, 1, 0};
        tbl[1]  = '{5, 48'h664F5B06C0, 48'h664F5B06,     1'b0, 3'd0, 1'b1, 1, 0};
        tbl[2]  = '{1, 48'h88,         48'h664F5B06,     1'b1, 3'd0, 1'b1, 1, 0};
        tbl[3]  = '{1, 48'h44,         48'h664F5B06,     1'b1, 3'd0, 1'b0, 1, 0};
        tbl[4]  = '{3, 48'h3F7FC2,     48'h663F5B06,     1'b1, 3'd0, 1'b0, 1, 0};
        tbl[5]  = '{1, 48'h40,         48'h663F5B06,     1'b1, 3'd0, 1'b1, 1, 0};
        tbl[6]  = '{3, 48'h2211C5,     48'h1100663F5B06, 1'b1, 3'd0, 1'b1, 1, 0};
        tbl[7]  = '{1, 48'h8F,         48'h1100663F5B06, 1'b1, 3'd7, 1'b1, 1, 0};
        tbl[8]  = '{2, 48'h0088,       48'h1100663F5B06, 1'b1, 3'd0, 1'b1, 0, 1};
        tbl[9]  = '{1, 48'h20,         48'h1100663F5B06, 1'b1, 3'd0, 1'b1, 0, 1};
        tbl[10] = '{1, 48'h8A,         48'h1100663F5B06, 1'b1, 3'd2, 1'b1, 1, 0};
        tbl[11] = '{2, 48'h55C7,       48'h1100663F5B06, 1'b1, 3'd2, 1'b1, 1, 0};

        // Reset state.
        wait_clk(3);
        check("rst_seg", seg_flat, 0);
        check("rst_disp", disp_on, 0);
        check("rst_bri", brightness, 0);
        check("rst_ai", auto_inc, 1);
        check("rst_fd", frame_done, 0);
        check("rst_pe", proto_err, 0);
        check("rst_bus", tm_dio, 1);
        rst_n = 1'b1;
        wait_clk(H);

        // Table of complete frames, state accumulates from row to row.
        for (int r = 0; r < 12; r++) begin
            fd0 = fd_cnt; pe0 = pe_cnt;
            start_cond();
            for (int k = 0; k < tbl[r].nb; k++) send_byte(tbl[r].bytes[8*k +: 8]);
            stop_cond();
            check($sformatf("row%0d_seg", r), seg_flat, tbl[r].seg);
            check($sformatf("row%0d_disp", r), disp_on, tbl[r].disp);
            check($sformatf("row%0d_bri", r), brightness, tbl[r].bri);
            check($sformatf("row%0d_ai", r), auto_inc, tbl[r].ai);
            check($sformatf("row%0d_fd", r), fd_cnt - fd0, tbl[r].fd);
            check($sformatf("row%0d_pe", r), pe_cnt - pe0, tbl[r].pe);
        end
        exp_seg = 48'h1100663F5B06;

        // Repeated START four bits into a data byte, then a clean frame.
        fd0 = fd_cnt; pe0 = pe_cnt;
        start_cond();
        send_byte(8'hC0);
        send_bits(8'hAA, 4);
        start_cond();
        check("abort_pe", pe_cnt - pe0, 1);
        check("abort_seg", seg_flat, exp_seg);
        send_byte(8'hC0);
        send_byte(8'h01);
        stop_cond();
        exp_seg[7:0] = 8'h01;
        check("after_abort_seg", seg_flat, exp_seg);
        check("after_abort_fd", fd_cnt - fd0, 1);
        check("after_abort_pe", pe_cnt - pe0, 1);

        // STOP in the middle of a byte.
        fd0 = fd_cnt; pe0 = pe_cnt;
        start_cond();
        send_byte(8'hC0);
        send_bits(8'h12, 3);
        stop_cond();
        check("stopmid_pe", pe_cnt - pe0, 1);
        check("stopmid_fd", fd_cnt - fd0, 0);
        check("stopmid_seg", seg_flat, exp_seg);

        // A written but uncommitted byte is discarded by a repeated START.
        fd0 = fd_cnt; pe0 = pe_cnt;
        start_cond();
        send_byte(8'hC0);
        send_byte(8'h77);
        start_cond();
        send_byte(8'hC1);
        send_byte(8'h33);
        stop_cond();
        exp_seg[15:8] = 8'h33;
        check("discard_seg", seg_flat, exp_seg);
        check("discard_fd", fd_cnt - fd0, 1);
        check("discard_pe", pe_cnt - pe0, 1);

        // Key read command.
        fd0 = fd_cnt; pe0 = pe_cnt;
        start_cond();
        send_byte(8'h42);
        rd = '0;
        for (int i = 0; i < 8; i++) begin
            tm_clk = 1'b1; wait_clk(H / 2);
            rd[i] = tm_dio;
            wait_clk(H / 2); tm_clk = 1'b0; wait_clk(H);
        end
        tm_clk = 1'b1; wait_clk(H);
        tm_clk = 1'b0; wait_clk(H);
        stop_cond();
`ifdef TM1637_KEYSCAN_EN
        rd_exp = 8'hA5;
        check("read_fd", fd_cnt - fd0, 1);
        check("read_pe", pe_cnt - pe0, 0);
`else
        rd_exp = 8'hFF;
        check("read_fd", fd_cnt - fd0, 0);
        check("read_pe", pe_cnt - pe0, 1);
`endif
        check("read_bits", rd, rd_exp);
        check("read_seg", seg_flat, exp_seg);

        // Reset while the ACK is being driven.
        start_cond();
        send_byte(8'hC0);
        send_bits(8'h55, 8);
        wait_clk(2); dio_low = 1'b0; wait_clk(2);
        check("ack_before_rst", tm_dio, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_bus", tm_dio, 1);
        check("rst_mid_state", {seg_flat, disp_on, brightness, auto_inc}, {48'h0, 1'b0, 3'd0, 1'b1});
        tm_clk = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(H);
        fd0 = fd_cnt; pe0 = pe_cnt;
        start_cond();
        send_byte(8'hC0);
        send_byte(8'h3F);
        stop_cond();
        check("post_rst_seg", seg_flat, 48'h3F);
        check("post_rst_fd", fd_cnt - fd0, 1);
        check("post_rst_pe", pe_cnt - pe0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
